// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the parking-gate keypad front end.
package pin_entry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FULL,
        ST_SUBMIT,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_ENT  = 4'hE;

    localparam int DIGITS_DEF  = 4;
    localparam int TIMEOUT_DEF = 50;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/pin_entry_if.sv
// Keypad-side inputs and gate-controller-side PIN outputs of pin_entry.
interface pin_entry_if
    import pin_entry_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
);
    logic                  s01;
    logic                  lock_alarm;
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   pass;
    logic                  pass_valid;
    logic [2:0]            digit_cnt;
    logic                  entry_err;
    logic                  busy;

    modport master (
        output s01, lock_alarm, key_valid, key_code,
        input  pass, pass_valid, digit_cnt, entry_err, busy
    );

    modport slave (
        input  s01, lock_alarm, key_valid, key_code,
        output pass, pass_valid, digit_cnt, entry_err, busy
    );
endinterface

// File: rtl/pin_entry_idle_timer.sv
// Counts key-free cycles while a partial PIN is buffered; flags the idle limit.
module idle_timer #(
    parameter int TIMEOUT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic reload,
    output logic expired
);
    localparam int             CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // A key in the expiring cycle suppresses the timeout.
    assign expired = run && !reload && (cnt == TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || reload || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/pin_entry.sv
// Keypad PIN collector: assembles hex digits into the pass word for the gate controller.
//   state      | meaning
//   ST_IDLE    | no car present, keys ignored, pass held at 0
//   ST_COLLECT | car present, accepting digits/edit keys
//   ST_FULL    | all digits entered, waiting for enter/edit
//   ST_SUBMIT  | one cycle: publish pass with pass_valid
//   ST_LOCKED  | controller alarm, everything cleared and frozen
module pin_entry
    import pin_entry_pkg::*;
#(
    parameter int DIGITS  = DIGITS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic        clk,
    input logic        rst,
    pin_entry_if.slave bus
);
    localparam int         W        = 4 * DIGITS;
    localparam logic [2:0] CNT_FULL = 3'(DIGITS);
    localparam logic [2:0] CNT_LAST = 3'(DIGITS - 1);

    state_t         state;
    logic [W-1:0]   pin_buf;
    logic [W-1:0]   pass_q;
    logic [2:0]     cnt_q;
    logic           pass_valid_q;
    logic           entry_err_q;
    logic           busy_q;
    logic           timer_run;
    logic           timer_expired;

    assign timer_run = ((state == ST_COLLECT) || (state == ST_FULL)) && (cnt_q != 3'd0);

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .reload  (bus.key_valid),
        .expired (timer_expired)
    );

    assign bus.pass       = pass_q;
    assign bus.pass_valid = pass_valid_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.entry_err  = entry_err_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            pin_buf      <= '0;
            pass_q       <= '0;
            cnt_q        <= '0;
            pass_valid_q <= 1'b0;
            entry_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pass_valid_q <= 1'b0;
            entry_err_q  <= 1'b0;
            if (bus.lock_alarm) begin
                state   <= ST_LOCKED;
                pin_buf <= '0;
                cnt_q   <= '0;
                pass_q  <= '0;
                busy_q  <= 1'b0;
            end else if (state == ST_LOCKED) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else if (!bus.s01) begin
                state   <= ST_IDLE;
                pin_buf <= '0;
                cnt_q   <= '0;
                pass_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_COLLECT;
                        busy_q <= 1'b1;
                    end
                    ST_SUBMIT: begin
                        pass_q       <= pin_buf;
                        pass_valid_q <= 1'b1;
                        pin_buf      <= '0;
                        cnt_q        <= '0;
                        state        <= ST_COLLECT;
                        busy_q       <= 1'b1;
                    end
                    ST_COLLECT, ST_FULL: begin
                        if (timer_expired) begin
                            pin_buf     <= '0;
                            cnt_q       <= '0;
                            entry_err_q <= 1'b1;
                            state       <= ST_COLLECT;
                        end else if (bus.key_valid) begin
                            if (state == ST_COLLECT) begin
                                if (is_digit(bus.key_code)) begin
                                    pin_buf <= {pin_buf[W-5:0], bus.key_code};
                                    cnt_q   <= cnt_q + 3'd1;
                                    if (cnt_q + 3'd1 == CNT_FULL) state <= ST_FULL;
                                end else if (bus.key_code == KEY_BKSP) begin
                                    if (cnt_q != 3'd0) begin
                                        pin_buf <= pin_buf >> 4;
                                        cnt_q   <= cnt_q - 3'd1;
                                    end
                                end else if (bus.key_code == KEY_CLR) begin
                                    pin_buf <= '0;
                                    cnt_q   <= '0;
                                end else if (bus.key_code == KEY_ENT) begin
                                    pin_buf     <= '0;
                                    cnt_q       <= '0;
                                    entry_err_q <= 1'b1;
                                end
                            end else begin
                                // Extra digits in FULL are silently dropped.
                                if (bus.key_code == KEY_BKSP) begin
                                    pin_buf <= pin_buf >> 4;
                                    cnt_q   <= CNT_LAST;
                                    state   <= ST_COLLECT;
                                end else if (bus.key_code == KEY_CLR) begin
                                    pin_buf <= '0;
                                    cnt_q   <= '0;
                                    state   <= ST_COLLECT;
                                end else if (bus.key_code == KEY_ENT) begin
                                    state  <= ST_SUBMIT;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry: vector table for key sequences, hand sequences for timing corners.
module tb_pin_entry;
    import pin_entry_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pin_entry_if #(.DIGITS(4)) bus();

    pin_entry #(.DIGITS(4), .TIMEOUT(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         kv;
        logic [3:0] code;
        logic [2:0] cnt;
        bit         pv;
        bit         err;
        logic [15:0] pass;
        bit         busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] cnt, input bit pv, input bit err,
                              input logic [15:0] pass, input bit busy);
        check(tag, "digit_cnt", 32'(bus.digit_cnt), 32'(cnt));
        check(tag, "pass_valid", 32'(bus.pass_valid), 32'(pv));
        check(tag, "entry_err", 32'(bus.entry_err), 32'(err));
        check(tag, "pass", 32'(bus.pass), 32'(pass));
        check(tag, "busy", 32'(bus.busy), 32'(busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic addv(input bit kv, input logic [3:0] c, input logic [2:0] n, input bit pv,
                        input bit err, input logic [15:0] p, input bit b);
        vec_t v;
        v.kv = kv; v.code = c; v.cnt = n; v.pv = pv; v.err = err; v.pass = p; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        // basic submit 4037
        addv(1, 4'h4, 3'd1, 0, 0, 16'h0000, 1);
        addv(1, 4'h0, 3'd2, 0, 0, 16'h0000, 1);
        addv(1, 4'h3, 3'd3, 0, 0, 16'h0000, 1);
        addv(1, 4'h7, 3'd4, 0, 0, 16'h0000, 1);
        addv(1, 4'hE, 3'd4, 0, 0, 16'h0000, 0);
        addv(0, 4'h0, 3'd0, 1, 0, 16'h4037, 1);
        addv(0, 4'h0, 3'd0, 0, 0, 16'h4037, 1);
        // backspace out of FULL
        addv(1, 4'h4, 3'd1, 0, 0, 16'h4037, 1);
        addv(1, 4'h0, 3'd2, 0, 0, 16'h4037, 1);
        addv(1, 4'h3, 3'd3, 0, 0, 16'h4037, 1);
        addv(1, 4'h1, 3'd4, 0, 0, 16'h4037, 1);
        addv(1, 4'hA, 3'd3, 0, 0, 16'h4037, 1);
        addv(1, 4'h7, 3'd4, 0, 0, 16'h4037, 1);
        addv(1, 4'hE, 3'd4, 0, 0, 16'h4037, 0);
        addv(0, 4'h0, 3'd0, 1, 0, 16'h4037, 1);
        addv(0, 4'h0, 3'd0, 0, 0, 16'h4037, 1);
        // short enter, then extra digit in FULL, key dropped during SUBMIT
        addv(1, 4'h4, 3'd1, 0, 0, 16'h4037, 1);
        addv(1, 4'h0, 3'd2, 0, 0, 16'h4037, 1);
        addv(1, 4'hE, 3'd0, 0, 1, 16'h4037, 1);
        addv(0, 4'h0, 3'd0, 0, 0, 16'h4037, 1);
        addv(1, 4'h4, 3'd1, 0, 0, 16'h4037, 1);
        addv(1, 4'h0, 3'd2, 0, 0, 16'h4037, 1);
        addv(1, 4'h2, 3'd3, 0, 0, 16'h4037, 1);
        addv(1, 4'h7, 3'd4, 0, 0, 16'h4037, 1);
        addv(1, 4'h9, 3'd4, 0, 0, 16'h4037, 1);
        addv(1, 4'hE, 3'd4, 0, 0, 16'h4037, 0);
        addv(1, 4'h5, 3'd0, 1, 0, 16'h4027, 1);
        addv(0, 4'h0, 3'd0, 0, 0, 16'h4027, 1);
        // ignored code, backspace at zero, clear in COLLECT and FULL
        addv(1, 4'hB, 3'd0, 0, 0, 16'h4027, 1);
        addv(1, 4'hA, 3'd0, 0, 0, 16'h4027, 1);
        addv(1, 4'h5, 3'd1, 0, 0, 16'h4027, 1);
        addv(1, 4'h6, 3'd2, 0, 0, 16'h4027, 1);
        addv(1, 4'hC, 3'd0, 0, 0, 16'h4027, 1);
        addv(1, 4'h1, 3'd1, 0, 0, 16'h4027, 1);
        addv(1, 4'h2, 3'd2, 0, 0, 16'h4027, 1);
        addv(1, 4'h3, 3'd3, 0, 0, 16'h4027, 1);
        addv(1, 4'h4, 3'd4, 0, 0, 16'h4027, 1);
        addv(1, 4'hC, 3'd0, 0, 0, 16'h4027, 1);

        rst            = 1'b0;
        bus.s01        = 1'b0;
        bus.lock_alarm = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        #2;
        check_outs("reset", 3'd0, 0, 0, 16'h0000, 0);
        tick();
        tick();
        rst     = 1'b1;
        bus.s01 = 1'b1;
        tick();
        check_outs("enter_collect", 3'd0, 0, 0, 16'h0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kv) key(vecs[i].code);
            else tick();
            check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pv, vecs[i].err, vecs[i].pass, vecs[i].busy);
        end

        // idle timeout exactly at 50 key-free cycles
        key(4'h4);
        key(4'h0);
        repeat (49) tick();
        check_outs("to_49", 3'd2, 0, 0, 16'h4027, 1);
        tick();
        check_outs("to_50", 3'd0, 0, 1, 16'h4027, 1);
        tick();
        check_outs("to_after", 3'd0, 0, 0, 16'h4027, 1);

        // key on cycle 49 restarts the timer
        key(4'h4);
        key(4'h0);
        repeat (48) tick();
        key(4'h3);
        check_outs("rl_key", 3'd3, 0, 0, 16'h4027, 1);
        tick();
        check_outs("rl_50", 3'd3, 0, 0, 16'h4027, 1);
        repeat (48) tick();
        check_outs("rl_49b", 3'd3, 0, 0, 16'h4027, 1);
        tick();
        check_outs("rl_50b", 3'd0, 0, 1, 16'h4027, 1);

        // lock alarm mid-entry
        key(4'h4);
        key(4'h0);
        bus.lock_alarm = 1'b1;
        tick();
        check_outs("lock", 3'd0, 0, 0, 16'h0000, 0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hE);
        tick();
        check_outs("lock_keys", 3'd0, 0, 0, 16'h0000, 0);
        bus.lock_alarm = 1'b0;
        tick();
        check_outs("unlock_idle", 3'd0, 0, 0, 16'h0000, 0);
        tick();
        check_outs("unlock_collect", 3'd0, 0, 0, 16'h0000, 1);

        // car leaves mid-entry
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hE);
        tick();
        check_outs("s01_submit", 3'd0, 1, 0, 16'h1234, 1);
        key(4'h5);
        key(4'h6);
        check_outs("s01_partial", 3'd2, 0, 0, 16'h1234, 1);
        bus.s01 = 1'b0;
        tick();
        check_outs("s01_low", 3'd0, 0, 0, 16'h0000, 0);
        key(4'h7);
        check_outs("s01_low_key", 3'd0, 0, 0, 16'h0000, 0);
        bus.s01 = 1'b1;
        tick();
        check_outs("s01_back", 3'd0, 0, 0, 16'h0000, 1);

        // async reset between edges while FULL
        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'hE);
        tick();
        check_outs("pre_rst_submit", 3'd0, 1, 0, 16'h9876, 1);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check_outs("pre_rst_full", 3'd4, 0, 0, 16'h9876, 1);
        #3;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 3'd0, 0, 0, 16'h0000, 0);
        #2;
        rst = 1'b1;
        tick();
        check_outs("rst_release", 3'd0, 0, 0, 16'h0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pin_entry.md
# pin_entry

Keypad front end for the parking-gate PIN controller. Collects hex key strobes from the entry keypad while a car is at the gate (`s01`). It assembles four digits into the 16-bit `pass` word consumed by the gate controller and marks each submission with a one-cycle `pass_valid`. It supports backspace and clear, drops stale entries on an idle timeout, and freezes while the controller reports `lock_alarm`.

## Interface
- `DIGITS`, 4: digits per PIN. The `pass` width is 4*`DIGITS`.
- `TIMEOUT`, 50: idle clock cycles before a partial entry is discarded. Must be ≥ 2.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous reset, active-low. Clears all state immediately on assertion.
- `s01`, in, 1: car-present sensor. Level-sensitive.
- `lock_alarm`, in, 1: lock indication from the gate controller. Level-sensitive.
- `key_valid`, in, 1: one-cycle strobe qualifying `key_code`.
- `key_code`, in, 4: key value.
  - 0x0–0x9: digit.
  - 0xA: backspace.
  - 0xC: clear.
  - 0xE: enter.
  - 0xB, 0xD, 0xF: ignored.
- `pass`, out, 4*`DIGITS`: last submitted PIN, most significant digit first.
- `pass_valid`, out, 1: one-cycle pulse; `pass` is new this cycle.
- `digit_cnt`, out, 3: digits currently buffered, 0..`DIGITS`.
- `entry_err`, out, 1: one-cycle pulse for a short enter or a timeout.
- `busy`, out, 1: high in COLLECT and FULL.

## Operation
- States: IDLE, COLLECT, FULL, SUBMIT, LOCKED.
- Internal registers: `buf` (4*`DIGITS` bits), `digit_cnt`, and an idle counter.
- Priority, highest first, evaluated each edge:
  1. `lock_alarm`
  2. `s01`=0
  3. timeout
  4. key
- `lock_alarm`=1 in any state → LOCKED. `buf`, `digit_cnt` and `pass` are cleared. Keys are ignored. Exit to IDLE when `lock_alarm`=0.
- IDLE:
  - Keys ignored. `pass`=0, `buf`=0.
  - `s01`=1 → COLLECT.
- COLLECT or FULL with `s01`=0 → IDLE. `buf` and `digit_cnt` are cleared; `pass` is cleared to 0.
- COLLECT key handling:
  - Digit: `buf` ← {`buf`[4*`DIGITS`-5:0], digit}; `digit_cnt`+1. When the count reaches `DIGITS` → FULL.
  - Backspace: `buf` ← `buf`>>4; `digit_cnt`−1. No-op at 0.
  - Clear: `buf`=0, `digit_cnt`=0.
  - Enter: `entry_err` pulse; `buf` and `digit_cnt` cleared; stay in COLLECT.
- FULL key handling:
  - Digit: ignored (no overflow, no error).
  - Backspace: → COLLECT with `digit_cnt`=`DIGITS`−1.
  - Clear: → COLLECT with 0 digits.
  - Enter: → SUBMIT.
- SUBMIT (exactly one cycle):
  - `pass` ← `buf`; `pass_valid`=1.
  - Next state is COLLECT, with `buf` and `digit_cnt` cleared so a retry can follow.
  - A key strobe arriving in SUBMIT is dropped.
- Idle timer:
  - Runs only in COLLECT/FULL with `digit_cnt`>0.
  - Reloads to 0 on every `key_valid`, including ignored codes.
  - At `TIMEOUT` consecutive key-free cycles: `buf` and `digit_cnt` cleared, `entry_err` pulse, timer reset, stay in (or return to) COLLECT.
- Timeout and key in the same cycle: the key wins, because it reloads the timer first.

## Timing
- Reset values: `pass`=0, `pass_valid`=0, `digit_cnt`=0, `entry_err`=0, `busy`=0, state IDLE.
- All outputs are registered.
- A key sampled at edge N updates `digit_cnt` at edge N.
- An enter sampled at edge N (in FULL) drives SUBMIT at edge N+1. `pass` and `pass_valid` are visible after edge N+1; `pass_valid` drops after edge N+2.
- `pass` holds its value after SUBMIT until the next SUBMIT, IDLE entry, LOCKED entry, or reset.
- Key strobes are assumed to be at least 1 cycle apart; back-to-back strobes are each processed.
- `rst` asserted mid-entry: outputs go to their reset values without waiting for a clock edge.
- `rst` release is synchronous to the next edge: the first edge after release evaluates state from IDLE.

## Structure
- `pin_entry_pkg` holds:
  - the state enum;
  - key-code constants `KEY_BKSP`=4'hA, `KEY_CLR`=4'hC, `KEY_ENT`=4'hE;
  - the default `DIGITS`.
- Sub-module `idle_timer`:
  - `$clog2(TIMEOUT+1)`-bit counter.
  - Inputs: `run` and `reload`.
  - Output: one-cycle `expired`.
- The FSM, shift buffer and output registers stay in `pin_entry`.

## Test plan
- Reset, `s01`=1, keys 4,0,3,7,E → `pass`=16'h4037 and one-cycle `pass_valid` 2 edges after E. `digit_cnt` then returns to 0.
- Keys 4,0,3,1,A,7,E → `pass`=16'h4037; `digit_cnt` sequence 1,2,3,4,3,4,0.
- Keys 4,0,E → `entry_err` pulse, `digit_cnt`=0, no `pass_valid`. Then 4,0,2,7,9,E → extra 9 ignored, `pass`=16'h4027.
- Keys 4,0 then 50 idle cycles → `entry_err` on cycle 50, `digit_cnt`=0. A key on cycle 49 → no error.
- Mid-entry `lock_alarm`=1 → LOCKED, `pass`=0, keys ignored, no `pass_valid`. `lock_alarm`=0 → IDLE; with `s01`=1 → COLLECT.
- Mid-entry `s01`=0 → IDLE, `pass`=0, `busy`=0. Async `rst`=0 between edges during FULL → all outputs 0 immediately.
